// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter register with conditional branch writes and a
// three-step exception entry (detect -> SAVE -> VECTOR).
//
// Ports
//   clk           : clock, all state updated on the rising edge
//   reset         : asynchronous active-low reset
//   pc_next       : candidate PC from the PC source mux
//   pc_write      : unconditional PC write request
//   pc_write_cond : branch PC write request, qualified by branch_type/zero/gt
//   branch_type   : 00 beq, 01 bne, 10 bgt, 11 ble
//   zero, gt      : ALU comparison flags
//   exc_opcode    : invalid-opcode exception request
//   exc_ovf       : overflow exception request
//   pc            : current program counter
//   epc           : PC of the instruction that raised the last exception (pc - 4)
//   cause         : 00 none, 01 opcode, 10 overflow, 11 alignment
//   exc_busy      : high while exception entry is in progress (SAVE, VECTOR)
//   pc_loaded     : one-cycle pulse after every edge that loaded pc
module pc_update_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] VEC_OPCODE = 32'h0000_0100,
    parameter logic [31:0] VEC_OVF    = 32'h0000_0104,
    parameter logic [31:0] VEC_ALIGN  = 32'h0000_0108
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        zero,
    input  logic        gt,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        exc_busy,
    output logic        pc_loaded
);

    localparam int unsigned PC_W    = 32;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_OVF    = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_ALIGN  = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_epc;
    logic [CAUSE_W-1:0]  r_cause;
    logic                r_exc_busy;
    logic                r_pc_loaded;

    state_t              w_state_next;
    logic                w_cond;
    logic                w_take;
    logic                w_misalign;
    logic [PC_W-1:0]     w_vector;
    logic                w_pc_load;
    logic [PC_W-1:0]     w_pc_new;
    logic                w_cause_load;
    logic [CAUSE_W-1:0]  w_cause_new;
    logic                w_epc_load;

    // Branch condition selected by branch_type
    always_comb begin
        w_cond = 1'b0;
        case (branch_type)
            2'b00:   w_cond = zero;
            2'b01:   w_cond = ~zero;
            2'b10:   w_cond = gt;
            default: w_cond = ~gt;
        endcase
    end

    assign w_take     = pc_write | (pc_write_cond & w_cond);
    assign w_misalign = w_take & (pc_next[1:0] != 2'b00);

    // Handler address for the latched cause
    always_comb begin
        w_vector = RESET_PC;
        case (r_cause)
            CAUSE_OPCODE: w_vector = VEC_OPCODE;
            CAUSE_OVF:    w_vector = VEC_OVF;
            CAUSE_ALIGN:  w_vector = VEC_ALIGN;
            default:      w_vector = RESET_PC;
        endcase
    end

    // Next-state and register-update decode
    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_pc_new     = r_pc;
        w_cause_load = 1'b0;
        w_cause_new  = r_cause;
        w_epc_load   = 1'b0;
        case (r_state)
            RUN: begin
                // An exception always wins over a simultaneous PC write
                if (exc_opcode) begin
                    w_cause_load = 1'b1;
                    w_cause_new  = CAUSE_OPCODE;
                    w_state_next = SAVE;
                end else if (exc_ovf) begin
                    w_cause_load = 1'b1;
                    w_cause_new  = CAUSE_OVF;
                    w_state_next = SAVE;
                end else if (w_misalign) begin
                    w_cause_load = 1'b1;
                    w_cause_new  = CAUSE_ALIGN;
                    w_state_next = SAVE;
                end else if (w_take) begin
                    w_pc_load = 1'b1;
                    w_pc_new  = pc_next;
                end
            end
            SAVE: begin
                w_epc_load   = 1'b1;
                w_state_next = VECTOR;
            end
            VECTOR: begin
                w_pc_load    = 1'b1;
                w_pc_new     = w_vector;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_pc        <= RESET_PC;
            r_epc       <= '0;
            r_cause     <= CAUSE_NONE;
            r_exc_busy  <= 1'b0;
            r_pc_loaded <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_exc_busy  <= (w_state_next != RUN);
            r_pc_loaded <= w_pc_load;
            if (w_pc_load) begin
                r_pc <= w_pc_new;
            end
            if (w_cause_load) begin
                r_cause <= w_cause_new;
            end
            // pc still holds the faulting value here; wraps modulo 2^32
            if (w_epc_load) begin
                r_epc <= r_pc - PC_W'(4);
            end
        end
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign cause     = r_cause;
    assign exc_busy  = r_exc_busy;
    assign pc_loaded = r_pc_loaded;

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL expose parameter VEC_OPCODE, default 32'h0000_0100, meaning the handler address for an invalid-opcode exception.
REQ-003 The block SHALL expose parameter VEC_OVF, default 32'h0000_0104, meaning the handler address for an overflow exception.
REQ-004 The block SHALL expose parameter VEC_ALIGN, default 32'h0000_0108, meaning the handler address for a misaligned-target exception.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pc_next, input, 32 bits: candidate PC from the PC source mux.
REQ-008 The block SHALL have port pc_write, input, 1 bit: unconditional PC write request.
REQ-009 The block SHALL have port pc_write_cond, input, 1 bit: conditional (branch) PC write request.
REQ-010 The block SHALL have port branch_type, input, 2 bits: 00 beq, 01 bne, 10 bgt, 11 ble.
REQ-011 The block SHALL have ports zero and gt, inputs, 1 bit each: ALU comparison flags.
REQ-012 The block SHALL have ports exc_opcode and exc_ovf, inputs, 1 bit each: exception requests from control.
REQ-013 The block SHALL have port pc, output, 32 bits: current program counter (registered).
REQ-014 The block SHALL have port epc, output, 32 bits: exception PC (registered).
REQ-015 The block SHALL have port cause, output, 2 bits: 00 none, 01 opcode, 10 overflow, 11 alignment (registered).
REQ-016 The block SHALL have port exc_busy, output, 1 bit: high while exception entry is in progress.
REQ-017 The block SHALL have port pc_loaded, output, 1 bit: one-cycle registered pulse after every PC update.

Function
REQ-018 The block SHALL implement an FSM with states RUN, SAVE and VECTOR.
REQ-019 The block SHALL evaluate the branch condition cond as: beq=zero, bne=!zero, bgt=gt, ble=!gt.
REQ-020 The block SHALL define the take condition as take = pc_write | (pc_write_cond & cond).
REQ-021 In RUN with no exception pending and take=1, the block SHALL set pc <= pc_next on the next rising edge.
REQ-022 The block SHALL define misalign as take & (pc_next[1:0] != 2'b00).
REQ-023 In RUN, exception priority SHALL be exc_opcode > exc_ovf > misalign; the block SHALL latch cause 01, 10 or 11 respectively and transition to SAVE.
REQ-024 When an exception is raised, the block SHALL drop any simultaneous PC write, and pc SHALL hold its value.
REQ-025 In SAVE, the block SHALL set epc <= pc - 4 (modulo 2^32; pc=0 gives 32'hFFFF_FFFC), SHALL leave pc unchanged, and SHALL transition to VECTOR.
REQ-026 In VECTOR, the block SHALL load pc with the vector selected by cause and SHALL return to RUN.
REQ-027 exc_busy SHALL be 1 exactly in SAVE and VECTOR.
REQ-028 The block SHALL ignore pc_write, pc_write_cond, exc_opcode and exc_ovf outside RUN.
REQ-029 pc_loaded SHALL be 1 in the cycle after any edge that changed the pc register, including vector loads, and 0 otherwise.
REQ-030 cause and epc SHALL hold their values until the next exception entry.
REQ-031 Exception entry SHALL take exactly 3 edges from detection to pc=vector: detect, SAVE, VECTOR.

Reset
REQ-032 While reset=0, the block SHALL immediately force pc=RESET_PC, epc=0, cause=00, state=RUN, exc_busy=0 and pc_loaded=0, independent of clk.
REQ-033 Reset asserted mid-exception (SAVE or VECTOR) SHALL abort entry with no epc or pc update; the first edge after release SHALL behave as RUN.

Verification
REQ-034 Directed test: pc_write=1, pc_next=32'h0000_0040 -> pc=32'h40 after 1 edge, pc_loaded=1 the following cycle.
REQ-035 Directed test: pc_write_cond=1, branch_type=01, zero=1, pc_next=32'h80 -> pc unchanged, pc_loaded=0; then zero=0 -> pc=32'h80.
REQ-036 Directed test: pc=32'h20, exc_ovf=1 together with pc_write=1 -> pc still 32'h20 after the detect edge; epc=32'h1C, cause=10, pc=32'h104 after 3 edges; exc_busy high for 2 cycles.
REQ-037 Directed test: pc_write=1, pc_next=32'h42 -> cause=11, pc=32'h108 after 3 edges; with exc_opcode=1 in the same cycle, cause=01 and pc=32'h100 instead.
REQ-038 Directed test: reset=0 pulsed during SAVE -> pc=RESET_PC, epc=0, cause=00 immediately; normal pc_write works on the first edge after release.
REQ-039 Directed test: pc=0, exc_opcode=1 -> epc=32'hFFFF_FFFC (wrap-around), pc=32'h100.
